button_level_ctrl: RTL and testbench

BUTTON_LEVEL_CTRL -- requirements
Module: button_level_ctrl

---
 rtl/gesture_av_pkg.sv | 18 +
 rtl/btn_debounce_repeat.sv | 104 ++++++++++
 rtl/button_level_ctrl.sv | 94 +++++++++
 tb/tb_button_level_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gesture_av_pkg.sv
// Shared types for the button level controller:
// per-button FSM states and counter wrap encodings.
package gesture_av_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEAT
   } btn_state_t;

   localparam int WRAP_SAT  = 0;
   localparam int WRAP_ROLL = 1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_repeat.sv
// One raw active-low button: synchroniser, debouncer and
// press/hold/auto-repeat FSM producing single-cycle step pulses.
module btn_debounce_repeat
   import gesture_av_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000
) (
   input  logic Clock,
   input  logic Reset,
   input  logic btn_n,
   output logic step
);

   localparam int STAB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMR_W  = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES) + 1);

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0]  REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

   logic              sync_meta;
   logic              sync_lvl;
   logic              level;
   logic [STAB_W-1:0] stab;
   logic [TMR_W-1:0]  timer;
   btn_state_t        state;

   logic flip;
   logic rise;
   logic fall;

   // The debounced level flips on the edge that completes the stable run,
   // so the FSM reacts to rise/fall in that same edge.
   assign flip = (sync_lvl != level) && (stab == STAB_LAST);
   assign rise = flip && sync_lvl;
   assign fall = flip && !sync_lvl;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sync_meta <= 1'b0;
         sync_lvl  <= 1'b0;
         level     <= 1'b0;
         stab      <= '0;
         timer     <= '0;
         step      <= 1'b0;
         state     <= IDLE;
      end else begin
         sync_meta <= ~btn_n;
         sync_lvl  <= sync_meta;
         step      <= 1'b0;

         if (sync_lvl != level) begin
            if (flip) begin
               level <= sync_lvl;
               stab  <= '0;
            end else begin
               stab <= stab + 1'b1;
            end
         end else begin
            stab <= '0;
         end

         unique case (state)
            IDLE: begin
               if (rise) begin
                  state <= PRESSED;
                  step  <= 1'b1;
                  timer <= '0;
               end
            end
            PRESSED: begin
               if (fall) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (timer == HOLD_LAST) begin
                  state <= REPEAT;
                  step  <= 1'b1;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            REPEAT: begin
               if (fall) begin
                  state <= IDLE;
                  timer <= '0;
               end else if (timer == REP_LAST) begin
                  step  <= 1'b1;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_level_ctrl.sv
// Up/down button level control: two debounced auto-repeat buttons
// drive a saturating or wrapping level counter with status flags.
module button_level_ctrl
   import gesture_av_pkg::*;
#(
   parameter int COUNT_W         = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int WRAP_MODE       = WRAP_SAT
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               btn_up,
   input  logic               btn_down,
   output logic [COUNT_W-1:0] count,
   output logic [2:0]         volume,
   output logic               changed,
   output logic               at_max,
   output logic               at_min
);

   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic               ROLL    = (WRAP_MODE == WRAP_ROLL);

   logic up_step;
   logic dn_step;

   btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_up (
      .Clock (Clock),
      .Reset (Reset),
      .btn_n (btn_up),
      .step  (up_step)
   );

   btn_debounce_repeat #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
   ) u_down (
      .Clock (Clock),
      .Reset (Reset),
      .btn_n (btn_down),
      .step  (dn_step)
   );

   // Simultaneous up and down steps cancel out.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         count   <= '0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         unique case (1'b1)
            (up_step && !dn_step): begin
               if (count != CNT_MAX) begin
                  count   <= count + 1'b1;
                  changed <= 1'b1;
               end else if (ROLL) begin
                  count   <= '0;
                  changed <= 1'b1;
               end
            end
            (dn_step && !up_step): begin
               if (count != '0) begin
                  count   <= count - 1'b1;
                  changed <= 1'b1;
               end else if (ROLL) begin
                  count   <= CNT_MAX;
                  changed <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign at_max = (count == CNT_MAX);
   assign at_min = (count == '0);

   generate
      if (COUNT_W >= 3) begin : g_vol
         assign volume = count[COUNT_W-1 -: 3];
      end else begin : g_vol_ext
         assign volume = 3'(count);
      end
   endgenerate

endmodule

// File: tb/tb_button_level_ctrl.sv
// Scoreboard bench for button_level_ctrl: saturating and wrapping
// instances share stimulus and are checked against a rule-level model.
module tb_button_level_ctrl;

   localparam int CW   = 4;
   localparam int DEB  = 4;
   localparam int HOLD = 16;
   localparam int REP  = 8;
   localparam int LIM  = (1 << CW) - 1;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   logic          Clock;
   logic          Reset;
   logic          btn_up;
   logic          btn_down;
   logic [CW-1:0] cnt_s, cnt_w;
   logic [2:0]    vol_s, vol_w;
   logic          chg_s, chg_w;
   logic          amx_s, amx_w;
   logic          amn_s, amn_w;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   exp_t q0[$];
   exp_t q1[$];
   int   chg0[$];
   int   chg1[$];

   int s1[2], s2[2], deb[2], run[2], held[2], stp[2];
   int mcnt[2];

   button_level_ctrl #(
      .COUNT_W(CW), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP), .WRAP_MODE(0)
   ) dut_sat (
      .Clock(Clock), .Reset(Reset), .btn_up(btn_up), .btn_down(btn_down),
      .count(cnt_s), .volume(vol_s), .changed(chg_s),
      .at_max(amx_s), .at_min(amn_s)
   );

   button_level_ctrl #(
      .COUNT_W(CW), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP), .WRAP_MODE(1)
   ) dut_wrap (
      .Clock(Clock), .Reset(Reset), .btn_up(btn_up), .btn_down(btn_down),
      .count(cnt_w), .volume(vol_w), .changed(chg_w),
      .at_max(amx_w), .at_min(amn_w)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int inst, input int val);
      exp_t e;
      e.cyc = cyc;
      e.val = val;
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Level arithmetic as stated: saturate or wrap at the limits.
   task automatic apply(input int inst, input bit is_up);
      int nxt;
      nxt = mcnt[inst];
      if (is_up) begin
         if (nxt < LIM) nxt++;
         else if (inst == 1) nxt = 0;
      end else begin
         if (nxt > 0) nxt--;
         else if (inst == 1) nxt = LIM;
      end
      if (nxt != mcnt[inst]) begin
         mcnt[inst] = nxt;
         push(inst, nxt);
      end
   endtask

   // One rising edge of the reference model. A press held for d cycles
   // past its debounced rise steps at d=0, d=HOLD, HOLD+REP, HOLD+2*REP...
   task automatic model_edge();
      int rose, fell, raw;
      if (Reset) begin
         for (int b = 0; b < 2; b++) begin
            s1[b] = 0; s2[b] = 0; deb[b] = 0; run[b] = 0;
            held[b] = -1; stp[b] = 0;
         end
         mcnt[0] = 0;
         mcnt[1] = 0;
         return;
      end
      if (stp[0] != stp[1]) begin
         apply(0, stp[0] == 1);
         apply(1, stp[0] == 1);
      end
      for (int b = 0; b < 2; b++) begin
         rose = 0;
         fell = 0;
         if (s2[b] != deb[b]) begin
            run[b]++;
            if (run[b] == DEB) begin
               deb[b] = s2[b];
               run[b] = 0;
               rose = deb[b];
               fell = !deb[b];
            end
         end else begin
            run[b] = 0;
         end
         stp[b] = 0;
         if (rose != 0) begin
            held[b] = 0;
            stp[b] = 1;
         end else if (fell != 0) begin
            held[b] = -1;
         end else if (deb[b] != 0) begin
            held[b]++;
            stp[b] = (held[b] == HOLD) ||
                     (held[b] > HOLD && ((held[b] - HOLD) % REP) == 0) ? 1 : 0;
         end
         raw = (b == 0) ? int'(btn_up) : int'(btn_down);
         s2[b] = s1[b];
         s1[b] = (raw == 0) ? 1 : 0;
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      cyc++;
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   function automatic bit peek(input int inst, output exp_t e);
      if (inst == 0 && q0.size() > 0) begin e = q0[0]; return 1; end
      if (inst == 1 && q1.size() > 0) begin e = q1[0]; return 1; end
      e.cyc = 0;
      e.val = 0;
      return 0;
   endfunction

   task automatic pop(input int inst);
      if (inst == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
   endtask

   task automatic mon_inst(input int inst, input logic [CW-1:0] c,
                           input logic ch, input logic amx,
                           input logic amn, input logic [2:0] vol);
      exp_t e;
      bit have;
      have = peek(inst, e);
      while (have && e.cyc < cyc) begin
         pop(inst);
         checks++;
         errors++;
         $display("FAIL sb_missed inst%0d: no changed pulse at cycle %0d, expected count %0d",
                  inst, e.cyc, e.val);
         have = peek(inst, e);
      end
      if (have && e.cyc == cyc) begin
         pop(inst);
         checks++;
         if (!ch || int'(c) != e.val) begin
            errors++;
            $display("FAIL sb_step inst%0d: got changed=%0b count=%0d, expected changed=1 count=%0d",
                     inst, ch, c, e.val);
         end
      end else if (ch) begin
         checks++;
         errors++;
         $display("FAIL sb_spurious inst%0d: got changed=1 count=%0d at cycle %0d, expected no change",
                  inst, c, cyc);
      end
      checks++;
      if (int'(c) != mcnt[inst] || amx != (mcnt[inst] == LIM) ||
          amn != (mcnt[inst] == 0) || int'(vol) != (mcnt[inst] >> 1)) begin
         errors++;
         $display("FAIL levels inst%0d: got count=%0d max=%0b min=%0b vol=%0d, expected count=%0d",
                  inst, c, amx, amn, vol, mcnt[inst]);
      end
      if (ch) begin
         if (inst == 0) chg0.push_back(cyc);
         else chg1.push_back(cyc);
      end
   endtask

   always @(negedge Clock) begin
      if (Reset) begin
         checks++;
         if (cnt_s != '0 || chg_s || !amn_s || amx_s || vol_s != '0 ||
             cnt_w != '0 || chg_w || !amn_w || amx_w || vol_w != '0) begin
            errors++;
            $display("FAIL reset_hold: got counts %0d/%0d changed %0b/%0b, expected 0/0 and 0/0",
                     cnt_s, cnt_w, chg_s, chg_w);
         end
      end else begin
         mon_inst(0, cnt_s, chg_s, amx_s, amn_s, vol_s);
         mon_inst(1, cnt_w, chg_w, amx_w, amn_w, vol_w);
      end
   end

   task automatic do_reset();
      while (q0.size() > 0 || q1.size() > 0) tick();
      Reset = 1'b1;
      idle(2);
      Reset = 1'b0;
      idle(2);
   endtask

   function automatic int at0(input int idx);
      return (chg0.size() > idx) ? chg0[idx] : -1000;
   endfunction

   function automatic int at1(input int idx);
      return (chg1.size() > idx) ? chg1[idx] : -1000;
   endfunction

   int p, r, n0, n1, c0, c1;
   int offs[5];

   initial begin
      offs[0] = 7; offs[1] = 23; offs[2] = 31; offs[3] = 39; offs[4] = 47;
      btn_up   = 1'b1;
      btn_down = 1'b1;
      Reset    = 1'b1;
      idle(3);
      chk("rst_count", int'(cnt_s), 0);
      chk("rst_at_min", int'(amn_s), 1);
      chk("rst_at_max", int'(amx_s), 0);
      chk("rst_changed", int'(chg_s), 0);
      chk("rst_volume", int'(vol_s), 0);
      Reset = 1'b0;
      idle(5);

      // clean single press
      n0 = chg0.size();
      btn_up = 1'b0;
      p = cyc;
      idle(10);
      btn_up = 1'b1;
      idle(20);
      chk("press_pulses", chg0.size() - n0, 1);
      chk("press_latency", at0(n0) - p, 7);
      chk("press_count", int'(cnt_s), 1);

      // bouncing contact never settles
      c0 = int'(cnt_s);
      n0 = chg0.size();
      repeat (5) begin
         btn_up = 1'b0;
         idle(2);
         btn_up = 1'b1;
         idle(2);
      end
      idle(20);
      chk("bounce_count", int'(cnt_s), c0);
      chk("bounce_pulses", chg0.size() - n0, 0);

      // long hold with auto-repeat
      do_reset();
      n0 = chg0.size();
      btn_up = 1'b0;
      p = cyc;
      idle(50);
      chk("hold_count", int'(cnt_s), 5);
      for (int k = 0; k < 5; k++) chk("hold_step_time", at0(n0 + k) - p, offs[k]);
      btn_up = 1'b1;
      idle(30);

      // climb to the top, then probe both limit behaviours
      do_reset();
      btn_up = 1'b0;
      idle(124);
      btn_up = 1'b1;
      idle(20);
      chk("top_sat", int'(cnt_s), LIM);
      chk("top_wrap", int'(cnt_w), LIM);
      chk("top_at_max", int'(amx_s), 1);
      n0 = chg0.size();
      n1 = chg1.size();
      btn_up = 1'b0;
      idle(10);
      btn_up = 1'b1;
      idle(20);
      chk("sat_hold_max", int'(cnt_s), LIM);
      chk("sat_no_pulse", chg0.size() - n0, 0);
      chk("wrap_to_zero", int'(cnt_w), 0);
      chk("wrap_pulse", chg1.size() - n1, 1);
      btn_down = 1'b0;
      idle(10);
      btn_down = 1'b1;
      idle(20);
      chk("wrap_to_max", int'(cnt_w), LIM);
      chk("sat_down", int'(cnt_s), LIM - 1);

      // both buttons on the same edge cancel
      c0 = int'(cnt_s);
      c1 = int'(cnt_w);
      n0 = chg0.size();
      btn_up   = 1'b0;
      btn_down = 1'b0;
      idle(10);
      btn_up   = 1'b1;
      btn_down = 1'b1;
      idle(20);
      chk("both_sat", int'(cnt_s), c0);
      chk("both_wrap", int'(cnt_w), c1);
      chk("both_pulses", chg0.size() - n0, 0);

      // reset in the middle of auto-repeat, button kept held
      btn_up = 1'b0;
      idle(35);
      while (q0.size() > 0 || q1.size() > 0) tick();
      Reset = 1'b1;
      idle(3);
      chk("midrst_count", int'(cnt_s), 0);
      Reset = 1'b0;
      r = cyc;
      n0 = chg0.size();
      idle(3);
      chk("midrst_quiet", int'(cnt_s), 0);
      idle(10);
      chk("midrst_repress", at0(n0) - r, 7);
      chk("midrst_count1", int'(cnt_w), 1);
      btn_up = 1'b1;
      idle(20);

      // random button activity against the model
      repeat (60) begin
         btn_up   = ($urandom_range(0, 2) != 0);
         btn_down = ($urandom_range(0, 2) != 0);
         idle($urandom_range(1, 45));
      end
      btn_up   = 1'b1;
      btn_down = 1'b1;
      idle(40);

      chk("sb_drain0", q0.size(), 0);
      chk("sb_drain1", q1.size(), 0);
      chk("log_consistent", int'(chg1.size() > 0), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
